// File: rtl/ifmap_ring_spad_pkg.sv
// Shared PE scratchpad package: default word width / depth and the pointer-wrap
// helper used by the ifmap, filter and psum scratchpads.
// Ports: none (package only).
package ifmap_ring_spad_pkg;

  // Default word width of every PE scratchpad.
  localparam int unsigned SPAD_DATA_W = 16;

  // Default ifmap window depth in words (need not be a power of two).
  localparam int unsigned IFMAP_DEPTH = 12;

  // Advance a circular pointer by inc slots, wrapping at depth.
  // Callers guarantee ptr < depth and inc <= depth, so one subtraction
  // is enough and no divider is inferred for non-power-of-two depths.
  function automatic int unsigned ptr_wrap_add(
    input int unsigned ptr,
    input int unsigned inc,
    input int unsigned depth
  );
    int unsigned sum;
    sum = ptr + inc;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

endpackage

// File: rtl/ifmap_ring_spad_ram.sv
// spad_ram: plain scratchpad storage array, one write port and one registered
// read port. No reset: contents survive reset and flush by design.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; re_i/raddr_i read request,
//        rdata_o registered read data (holds when re_i is low).
module spad_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write on a same-address collision; the ring controller
  // never reads the slot it is writing, so the ordering is never observed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifmap_ring_spad.sv
// ifmap_ring_spad: circular ifmap window buffer for a PE. Words are pushed at
// the tail, read at any offset from the oldest word with 1-cycle latency, and
// retired from the head in groups (window slide).
// Ports: clk/reset (sync, active-high); clear flush; in_valid/in_data/in_ready
//        push side; rd_en/rd_offset -> rd_data/rd_valid/rd_err read side;
//        slide_en/slide_cnt retire; count/full/empty occupancy status.
module ifmap_ring_spad
  import ifmap_ring_spad_pkg::*;
#(
  parameter int unsigned DATA_W = SPAD_DATA_W,
  parameter int unsigned DEPTH  = IFMAP_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              slide_en,
  input  logic [ADDR_W:0]   slide_cnt,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  // Forces rd_data to zero after reset or an out-of-range read; the RAM
  // output register has no reset of its own.
  logic              rd_zero_q, rd_zero_d;

  logic              push;
  logic [ADDR_W:0]   eff;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Status comes from registered count only, so in_ready never depends on
  // a same-cycle slide.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

  always_comb begin
    push        = in_valid && in_ready && !clear;

    eff         = '0;
    if (slide_en) begin
      eff = (slide_cnt < count_q) ? slide_cnt : count_q;
    end

    // Range check and address use the pre-push count and pre-slide head.
    rd_in_range = ({1'b0, rd_offset} < count_q);
    // An out-of-range offset may exceed DEPTH; steer it to offset 0 so the
    // address stays inside the array (the data is discarded anyway).
    rd_addr     = ADDR_W'(ptr_wrap_add(32'(head_q),
                                       rd_in_range ? 32'(rd_offset) : 32'd0,
                                       DEPTH));

    ram_we      = push && !reset;
    ram_re      = rd_en && rd_in_range && !clear && !reset;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    rd_zero_d  = rd_zero_q;

    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = ADDR_W'(ptr_wrap_add(32'(head_q), 32'(eff), DEPTH));
      if (push) begin
        tail_d = ADDR_W'(ptr_wrap_add(32'(tail_q), 32'd1, DEPTH));
      end
      count_d = count_q + (ADDR_W + 1)'(push) - eff;

      if (rd_en) begin
        rd_valid_d = rd_in_range;
        rd_err_d   = !rd_in_range;
        rd_zero_d  = !rd_in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  spad_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (tail_q),
    .wdata_i (in_data),
    .re_i    (ram_re),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_data  = rd_zero_q ? '0 : ram_rdata;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: doc/ifmap_ring_spad.md
IFMAP_RING_SPAD -- requirements
Module: ifmap_ring_spad

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 16, word width in bits.
REQ-003 Parameter DEPTH, default 12, number of words (>=2, need not be a power of two).
REQ-004 Parameter ADDR_W, default $clog2(DEPTH), slot index and read-offset width.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous reset, active-high.
REQ-007 clear  input  1  flush: empties the buffer.
REQ-008 in_valid  input  1  write-side word valid.
REQ-009 in_data  input  DATA_W  write-side word.
REQ-010 in_ready  output  1  write side can accept a word.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_offset  input  ADDR_W  read position relative to the oldest stored word.
REQ-013 rd_data  output  DATA_W  read result.
REQ-014 rd_valid  output  1  rd_data valid this cycle.
REQ-015 rd_err  output  1  the read request was out of range.
REQ-016 slide_en  input  1  retire the oldest words (window advance).
REQ-017 slide_cnt  input  ADDR_W+1  number of words to retire.
REQ-018 count  output  ADDR_W+1  current occupancy.
REQ-019 full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-020 Storage SHALL be a circular buffer: head pointer (oldest word), tail pointer (next write slot), occupancy count; both pointers wrap from DEPTH-1 to 0.
REQ-021 in_ready SHALL equal !full, combinational from registered count only, with no dependence on slide_en.
REQ-022 Push: when in_valid && in_ready, in_data SHALL be written at tail and tail SHALL advance by 1 (mod DEPTH).
REQ-023 Read: rd_en SHALL register rd_data = mem[(head + rd_offset) mod DEPTH] and rd_valid=1 on the next cycle (1-cycle latency).
REQ-024 Read validity: if rd_offset >= count, the next cycle SHALL show rd_valid=0, rd_err=1, rd_data=0.
REQ-025 With no rd_en, the next cycle SHALL show rd_valid=0 and rd_err=0, and rd_data SHALL hold its last value.
REQ-026 Slide: when slide_en is asserted, eff = min(slide_cnt, count); head SHALL advance by eff (mod DEPTH).
REQ-027 A slide with slide_cnt > count SHALL empty the buffer and flag no error.
REQ-028 Simultaneous push, slide and read in one cycle SHALL all be legal.
REQ-029 In that case, count_next = count + push - eff.
REQ-030 In that case, the read SHALL use the pre-slide head and the pre-push count.
REQ-031 clear SHALL set head=tail=count=0.
REQ-032 clear SHALL take priority over push and slide, and the read in that cycle SHALL return rd_valid=0, rd_err=0.
REQ-033 Memory contents SHALL NOT be reset or cleared; only pointers are affected.

Reset
REQ-034 On reset: head=0, tail=0, count=0, rd_data=0, rd_valid=0, rd_err=0.
REQ-035 After reset, empty=1, full=0 and in_ready=1.
REQ-036 Reset SHALL override clear, push, slide and read in the same cycle.
REQ-037 Reset asserted mid-operation SHALL discard all stored words.

Structure
REQ-038 Default DATA_W/DEPTH and the pointer-wrap helper function SHALL live in the shared PE package, reused by the filter and psum scratchpads.
REQ-039 The memory array SHALL be a sub-module spad_ram: one write port, one registered read port, no reset.
REQ-040 Pointer/count control SHALL remain in ifmap_ring_spad.

Verification (DEPTH=12, DATA_W=16)
REQ-041 Reset: assert reset 2 cycles -> count=0, empty=1, in_ready=1, rd_valid=0, rd_data=0x0000.
REQ-042 Fill: push 0x0101..0x010C on consecutive cycles -> full=1, in_ready=0 after the 12th push; a 13th in_valid is not written and count stays 12.
REQ-043 Read: with count=12, rd_offset=2 -> next cycle rd_data=0x0103, rd_valid=1; with count=5, rd_offset=5 -> rd_err=1, rd_valid=0, rd_data=0.
REQ-044 Concurrent: at count=11 (0x0101..0x010B), same cycle push 0x0AAA, slide_cnt=3, rd_offset=0 -> rd_data=0x0101, count=9; then rd_offset=0 -> 0x0104, rd_offset=8 -> 0x0AAA.
REQ-045 Wrap: stream 30 words 0x0001..0x001E, sliding 1 per word once count=3, reading offsets 0..2 each cycle -> each window is three consecutive values in order across two pointer wraps.
REQ-046 Clear/reset mid-stream: clear at count=7 with rd_en -> count=0, rd_valid=0; slide_cnt=5 at count=2 -> count=0, no error.
